// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit
// Brief    : Owns the architectural PC, issues one-outstanding instruction
//            fetches and hands instruction/PC pairs to decode. Redirects
//            taken mid-fetch squash the stale response.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic            fetch_fault
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,  // ready to issue a request at pc
        S_WAIT  = 2'd1,  // request accepted, response pending
        S_HOLD  = 2'd2,  // instruction presented to decode
        S_DRAIN = 2'd3   // redirected while pending; discard the response
    } state_t;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    state_t          state, state_next;
    logic [XLEN-1:0] pc, pc_next;
    logic [XLEN-1:0] req_pc, req_pc_next;
    logic            inst_valid_next;
    logic [XLEN-1:0] inst_data_next;
    logic [XLEN-1:0] inst_pc_next;
    logic            fault_next;
    logic            redirect_ok;

    // A redirect is only honoured for word-aligned targets
    assign redirect_ok    = branch_taken && (branch_target[1:0] == 2'b00);
    assign imem_req_valid = (state == S_FETCH) && !stall && !branch_taken;
    assign imem_req_addr  = pc;

    // State and datapath registers, synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            req_pc      <= '0;
            inst_valid  <= 1'b0;
            inst_data   <= '0;
            inst_pc     <= '0;
            fetch_fault <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            req_pc      <= req_pc_next;
            inst_valid  <= inst_valid_next;
            inst_data   <= inst_data_next;
            inst_pc     <= inst_pc_next;
            fetch_fault <= fault_next;
        end
    end

    // Next-state and next-datapath decode
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        req_pc_next     = req_pc;
        inst_valid_next = inst_valid;
        inst_data_next  = inst_data;
        inst_pc_next    = inst_pc;
        fault_next      = branch_taken && (branch_target[1:0] != 2'b00);

        case (state)
            S_FETCH: begin
                // Request valid already excludes branch_taken, so a redirect
                // and a handshake never coincide here.
                if (redirect_ok) begin
                    pc_next = branch_target;
                end else if (imem_req_valid && imem_req_ready) begin
                    req_pc_next = pc;
                    state_next  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_ok) begin
                    pc_next    = branch_target;
                    state_next = imem_resp_valid ? S_FETCH : S_DRAIN;
                end else if (imem_resp_valid) begin
                    inst_data_next  = imem_resp_data;
                    inst_pc_next    = req_pc;
                    inst_valid_next = 1'b1;
                    state_next      = S_HOLD;
                end
            end
            S_DRAIN: begin
                if (redirect_ok) begin
                    pc_next = branch_target;
                end
                if (imem_resp_valid) begin
                    state_next = S_FETCH;
                end
            end
            S_HOLD: begin
                // Redirect wins over a same-cycle consume
                if (redirect_ok) begin
                    inst_valid_next = 1'b0;
                    pc_next         = branch_target;
                    state_next      = S_FETCH;
                end else if (inst_ready) begin
                    inst_valid_next = 1'b0;
                    pc_next         = inst_pc + PC_STEP;
                    state_next      = S_FETCH;
                end
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_unit
// Brief    : Randomized bench for pc_fetch_unit against a transaction-level
//            reference model and a variable-latency memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        fetch_fault;

    pc_fetch_unit #(
        .XLEN     (32),
        .RESET_PC (RST_PC)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .stall           (stall),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .fetch_fault     (fetch_fault)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: PC, whether a fetch is outstanding (and whether its
    // response is already doomed), and the instruction currently offered.
    logic [31:0] m_pc, m_req_addr, m_inst, m_ipc;
    bit          m_busy, m_squash, m_have, m_fault;

    // Memory model: one pending request with a cycle countdown
    bit          mem_pending;
    int          mem_cnt;
    logic [31:0] mem_addr;

    logic [31:0] tgt_tbl [0:6];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic bit pct(input int p);
        return $urandom_range(0, 99) < p;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RST_PC; m_req_addr = '0; m_inst = '0; m_ipc = '0;
        m_busy = 0; m_squash = 0; m_have = 0; m_fault = 0;
        mem_pending = 0; mem_cnt = 0; mem_addr = '0;
    endtask

    // One clock cycle: drive, check outputs, then advance both models
    task automatic step(input int p_stall, input int p_bt, input int p_rr,
                        input int p_ir, input int max_lat, input int p_rst);
        bit          rst_now, exp_req, redir, hs, dut_hs;
        logic [31:0] dut_addr;
        @(negedge clock);
        rst_now         = (p_rst > 0) && ($urandom_range(0, 999) < p_rst);
        reset           = rst_now;
        stall           = pct(p_stall);
        branch_taken    = pct(p_bt);
        branch_target   = pct(50) ? tgt_tbl[$urandom_range(0, 6)] : $urandom;
        imem_req_ready  = pct(p_rr);
        inst_ready      = pct(p_ir);
        imem_resp_valid = mem_pending && (mem_cnt == 0) && !rst_now;
        imem_resp_data  = imem_resp_valid ? mem_word(mem_addr) : $urandom;
        #1;
        exp_req = !m_busy && !m_have && !stall && !branch_taken;
        check("req_valid", 32'(imem_req_valid), 32'(exp_req));
        check("req_addr",  imem_req_addr, m_pc);
        check("inst_valid", 32'(inst_valid), 32'(m_have));
        check("inst_data", inst_data, m_inst);
        check("inst_pc",   inst_pc, m_ipc);
        check("fault",     32'(fetch_fault), 32'(m_fault));
        dut_hs   = imem_req_valid && imem_req_ready;
        dut_addr = imem_req_addr;
        @(posedge clock);
        if (rst_now) begin
            model_reset();
        end else begin
            redir   = branch_taken && (branch_target[1:0] == 2'b00);
            m_fault = branch_taken && (branch_target[1:0] != 2'b00);
            hs      = exp_req && imem_req_ready;
            if (m_have) begin
                if (redir) begin
                    m_have = 0; m_pc = branch_target;
                end else if (inst_ready) begin
                    m_have = 0; m_pc = m_ipc + 32'd4;
                end
            end else if (m_busy) begin
                if (imem_resp_valid) begin
                    m_busy = 0;
                    if (!m_squash && !redir) begin
                        m_have = 1; m_inst = mem_word(m_req_addr); m_ipc = m_req_addr;
                    end
                    m_squash = 0;
                end else if (redir) begin
                    m_squash = 1;
                end
                if (redir) m_pc = branch_target;
            end else begin
                if (redir) m_pc = branch_target;
                else if (hs) begin
                    m_busy = 1; m_squash = 0; m_req_addr = m_pc;
                end
            end
            if (imem_resp_valid) mem_pending = 0;
            else if (mem_pending && mem_cnt > 0) mem_cnt--;
            if (dut_hs && !mem_pending) begin
                mem_pending = 1;
                mem_cnt     = $urandom_range(0, max_lat);
                mem_addr    = dut_addr;
            end
        end
    endtask

    initial begin
        tgt_tbl[0] = 32'h0000_0200; tgt_tbl[1] = 32'h0000_0040;
        tgt_tbl[2] = 32'h0000_0202; tgt_tbl[3] = 32'hFFFF_FFFC;
        tgt_tbl[4] = 32'h0000_0000; tgt_tbl[5] = 32'h0000_0001;
        tgt_tbl[6] = 32'h0000_0103;
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        inst_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        // Straight-line fetch from RST_PC with zero-wait memory
        for (int i = 0; i < 60; i++) step(0, 0, 100, 100, 0, 0);
        // Mixed traffic
        for (int i = 0; i < 1500; i++) step(15, 15, 70, 60, 2, 0);
        // Redirect-heavy, including misaligned targets and wrap at top
        for (int i = 0; i < 1500; i++) step(10, 40, 80, 50, 3, 0);
        // Stalls, back-pressure and occasional mid-run reset
        for (int i = 0; i < 1500; i++) step(50, 10, 40, 30, 3, 8);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Owns the architectural program counter and issues instruction fetches to instruction memory.
- Uses one outstanding request with a valid/ready handshake.
- Consumes the branch target produced by the PC+immediate adder, and hands fetched instructions plus their PC to decode.
- Redirects cleanly while a fetch is in flight by squashing the stale response.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, width of PC, address and instruction.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- stall  input  1  hazard stall; blocks new fetch requests.
- branch_taken  input  1  redirect request, sampled every cycle.
- branch_target  input  XLEN  redirect PC (PC+immediate).
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  XLEN  fetch address.
- imem_resp_valid  input  1  response data valid (exactly one per accepted request).
- imem_resp_data  input  XLEN  fetched instruction.
- inst_valid  output  1  instruction available to decode.
- inst_ready  input  1  decode accepts instruction.
- inst_data  output  XLEN  instruction to decode.
- inst_pc  output  XLEN  PC of inst_data; feeds the branch adder.
- fetch_fault  output  1  one-cycle pulse: misaligned redirect rejected.

Behaviour:
- Reset is synchronous and active-high on clock. After the reset edge:
  - pc=RESET_PC, state=FETCH, inst_valid=0, inst_data=0, inst_pc=0, fetch_fault=0.
  - A reset mid-operation abandons any outstanding request. The bench must not return a response for it.
- FSM states: FETCH, WAIT, HOLD, DRAIN.
- A redirect is valid when branch_taken=1 and branch_target[1:0]==2'b00.
  - branch_taken=1 with target[1:0]!=0: redirect ignored, fetch_fault=1 next cycle, pc unchanged.
- imem_req_valid = (state==FETCH) & ~stall & ~branch_taken (combinational). imem_req_addr = pc.
- FETCH:
  - Valid redirect: pc<=branch_target, stay in FETCH.
  - Request handshake (valid & ready): latch req_pc<=pc, go to WAIT.
  - Otherwise hold state.
- WAIT:
  - Valid redirect, any resp_valid: pc<=target. Go to FETCH if resp_valid this cycle (response discarded), else go to DRAIN.
  - resp_valid without redirect: inst_data<=resp_data, inst_pc<=req_pc, inst_valid<=1, go to HOLD.
- DRAIN: wait for resp_valid, discard the data, go to FETCH. Redirects in DRAIN update pc; the latest one wins.
- HOLD: inst_valid=1, inst_data and inst_pc stable.
  - Valid redirect (priority over inst_ready): inst_valid<=0, pc<=target, go to FETCH.
  - inst_ready=1: inst_valid<=0, pc<=inst_pc+4, go to FETCH.
- stall only gates the request in FETCH. It does not affect WAIT, DRAIN or HOLD.
- PC arithmetic is modulo 2^XLEN: 32'hFFFF_FFFC+4 wraps to 0.
- Latency from request acceptance to inst_valid is memory latency +1 cycle. Minimum spacing between consecutive instructions is 3 cycles with zero-wait memory.
- inst_valid never falls without inst_ready or a redirect.

Test Plan:
- Reset with RESET_PC=0x100, zero-wait memory, inst_ready=1 -> addresses 0x100, 0x104, 0x108 fetched in order; inst_pc matches each address.
- Redirect to 0x200 while in WAIT, response arriving 2 cycles later -> that response is dropped (inst_valid stays 0); next request address is 0x200.
- branch_taken=1 with target 0x202 while in HOLD -> fetch_fault pulses 1 cycle; inst stays valid; the next fetch after inst_ready is inst_pc+4.
- Redirect and inst_ready in the same HOLD cycle, target 0x40 -> instruction not consumed as sequential; next request address is 0x40.
- stall=1 for 5 cycles in FETCH -> imem_req_valid=0 throughout; on release, request is issued at the same pc; imem_req_ready held low for 3 cycles delays the transition to WAIT accordingly.
- pc=0xFFFF_FFFC accepted -> next request address is 0x0000_0000.
